// File: rtl/rv_instr_encoder.sv
// rv_instr_encoder: packs decoded RV64I instruction descriptions into machine words and streams them to instruction memory
// Ports: clk/rst (async active-high); start begins a session; in_valid/in_ready handshake the description
// (kind, rd, rs1, rs2, funct3, f7b5, imm); imem_we/imem_addr/imem_wdata/imem_ready form the memory write port;
// count = words written this session, done = DONE state, err = sticky immediate range error.
// Optional macro RV_ENC_RANGE_CHECK_EN enables immediate range checking; otherwise err is tied low.
module rv_instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  kind,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic        f7b5,
  input  logic [31:0] imm,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  input  logic        imem_ready,
  output logic [15:0] count,
  output logic        done,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  state_t state, state_n;
  logic [31:0] word, code;
  logic accept, restart;
  // the pending write counts against the session budget so the last slot is never over-committed
  assign in_ready = state == LOAD && (32'(count) + 32'(imem_we) < DEPTH) && (!imem_we || imem_ready);
  assign accept = in_valid && in_ready;
  assign restart = state != LOAD && start;
  assign done = state == DONE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = start ? LOAD : IDLE;
      LOAD: state_n = (32'(count) == DEPTH || (!in_valid && !imem_we && count != 16'd0)) ? DONE : LOAD;
      DONE: state_n = start ? LOAD : DONE;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    word = '0;
    case (kind)
      4'd1:  word = {1'b0, f7b5, 5'b0, rs2, rs1, funct3, rd, 7'b0110011};
      4'd2:  word = {imm[11:0], rs1, funct3, rd, 7'b0010011};
      4'd3:  word = {1'b0, f7b5, 4'b0, imm[5:0], rs1, funct3, rd, 7'b0010011};
      4'd4:  word = {imm[11:0], rs1, 3'b011, rd, 7'b0000011};
      4'd5:  word = {imm[11:5], rs2, rs1, 3'b011, imm[4:0], 7'b0100011};
      4'd6:  word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 7'b1100011};
      4'd7:  word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
      4'd8:  word = {imm[11:0], rs1, 3'b000, rd, 7'b1100111};
      4'd9:  word = {imm[19:0], rd, 7'b0010111};
      4'd10: word = {imm[19:0], rd, 7'b0110111};
      default: word = '0;
    endcase
  end
`ifdef RV_ENC_RANGE_CHECK_EN
  logic signed [31:0] simm;
  logic bad;
  assign simm = imm;
  always_comb begin
    bad = 1'b0;
    case (kind)
      4'd2, 4'd4, 4'd5, 4'd8: bad = simm < -2048 || simm > 2047;
      4'd3: bad = |imm[31:6];
      4'd6: bad = simm < -4096 || simm > 4094 || imm[0];
      4'd7: bad = simm < -1048576 || simm > 1048574 || imm[0];
      default: bad = 1'b0;
    endcase
  end
  // out-of-range immediates still occupy a slot, written as NOP
  assign code = bad ? '0 : word;
  always_ff @(posedge clk or posedge rst)
    if (rst) err <= 1'b0;
    else if (restart) err <= 1'b0;
    else if (accept && bad) err <= 1'b1;
`else
  logic unused_imm;
  assign unused_imm = ^imm[31:21];
  assign code = word;
  assign err = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      imem_we <= 1'b0;
      imem_addr <= BASE_ADDR;
      imem_wdata <= '0;
      count <= '0;
    end else begin
      state <= state_n;
      if (restart) begin
        imem_addr <= BASE_ADDR;
        count <= '0;
      end else if (imem_we && imem_ready) begin
        imem_addr <= imem_addr + 32'd4;
        count <= count + 16'd1;
      end
      if (accept) begin
        imem_wdata <= code;
        imem_we <= 1'b1;
      end else if (imem_ready) imem_we <= 1'b0;
    end
endmodule

// File: tb/tb_rv_instr_encoder.sv
// tb_rv_instr_encoder: directed self-checking bench for rv_instr_encoder
module tb_rv_instr_encoder;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0, imem_ready = 1'b1;
  logic [3:0] kind = '0;
  logic [4:0] rd = '0, rs1 = '0, rs2 = '0;
  logic [2:0] funct3 = '0;
  logic f7b5 = 1'b0;
  logic [31:0] imm = '0;
  logic in_ready, imem_we, done, err;
  logic [31:0] imem_addr, imem_wdata;
  logic [15:0] count;
  logic in_ready2, imem_we2, done2, err2;
  logic [31:0] imem_addr2, imem_wdata2;
  logic [15:0] count2;
  int errors = 0, checks = 0;
  logic [31:0] fmt_exp [5] = '{32'h4031D213, 32'h008000EF, 32'h00008067, 32'h00001117, 32'h00000000};

  always #5 clk = ~clk;

  rv_instr_encoder dut (.clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .kind(kind), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .f7b5(f7b5), .imm(imm),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .imem_ready(imem_ready),
    .count(count), .done(done), .err(err));

  rv_instr_encoder #(.BASE_ADDR(32'h0000_0100), .DEPTH(2)) dut2 (.clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready2), .kind(kind), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
    .f7b5(f7b5), .imm(imm), .imem_we(imem_we2), .imem_addr(imem_addr2), .imem_wdata(imem_wdata2),
    .imem_ready(imem_ready), .count(count2), .done(done2), .err(err2));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic drive(input logic [3:0] k, input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [2:0] f3, input logic f7, input logic [31:0] im);
    kind = k; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; f7b5 = f7; imm = im;
  endtask

  task automatic test_reset;
    tick();
    tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    checks++; if (imem_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", imem_we); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 0", imem_addr); end
    checks++; if (imem_addr2 !== 32'h100) begin errors++; $display("FAIL reset_addr2 got %h want 100", imem_addr2); end
    checks++; if (imem_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h want 0", imem_wdata); end
    checks++; if ({count, done, err} !== 18'h0) begin errors++; $display("FAIL reset_cnt_done_err got %h want 0", {count, done, err}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_r_type;
    pulse_start();
    drive(4'd1, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'h0);
    in_valid = 1'b1;
    imem_ready = 1'b1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL r_in_ready got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (imem_we !== 1'b1) begin errors++; $display("FAIL r_we got %b want 1", imem_we); end
    checks++; if (imem_wdata !== 32'h002081B3) begin errors++; $display("FAIL r_word got %h want 002081b3", imem_wdata); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL r_addr got %h want 0", imem_addr); end
    tick();
    checks++; if (count !== 16'd1) begin errors++; $display("FAIL r_count got %0d want 1", count); end
    checks++; if (imem_we !== 1'b0) begin errors++; $display("FAIL r_we_clear got %b want 0", imem_we); end
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL r_done got %b want 1", done); end
  endtask

  task automatic test_back_to_back;
    pulse_start();
    checks++; if (done !== 1'b0 || count !== 16'd0) begin errors++; $display("FAIL b2b_restart got done=%b count=%0d want 0/0", done, count); end
    drive(4'd2, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5);
    in_valid = 1'b1;
    tick();
    drive(4'd4, 5'd5, 5'd2, 5'd0, 3'd0, 1'b0, 32'd8);
    checks++; if (imem_wdata !== 32'h00500093 || imem_addr !== 32'h0) begin errors++; $display("FAIL b2b_w0 got %h@%h want 00500093@0", imem_wdata, imem_addr); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (imem_wdata !== 32'h00813283 || imem_addr !== 32'h4) begin errors++; $display("FAIL b2b_w1 got %h@%h want 00813283@4", imem_wdata, imem_addr); end
    checks++; if (count !== 16'd1 || imem_we !== 1'b1) begin errors++; $display("FAIL b2b_mid got count=%0d we=%b want 1/1", count, imem_we); end
    tick();
    checks++; if (count !== 16'd2 || imem_addr !== 32'h8) begin errors++; $display("FAIL b2b_end got count=%0d addr=%h want 2/8", count, imem_addr); end
    tick();
  endtask

  task automatic test_stall;
    pulse_start();
    drive(4'd5, 5'd0, 5'd2, 5'd5, 3'd0, 1'b0, 32'd16);
    in_valid = 1'b1;
    imem_ready = 1'b0;
    tick();
    drive(4'd10, 5'd7, 5'd0, 5'd0, 3'd0, 1'b0, 32'h0001_2345);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (imem_we !== 1'b1 || imem_wdata !== 32'h00513823 || imem_addr !== 32'h0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold%0d got we=%b %h@%h rdy=%b want 1 00513823@0 0", i, imem_we, imem_wdata, imem_addr, in_ready);
      end
      tick();
    end
    imem_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (imem_wdata !== 32'h123453B7 || imem_addr !== 32'h4 || count !== 16'd1) begin errors++; $display("FAIL stall_lui got %h@%h count=%0d want 123453b7@4 1", imem_wdata, imem_addr, count); end
    tick();
    checks++; if (count !== 16'd2) begin errors++; $display("FAIL stall_count got %0d want 2", count); end
    tick();
  endtask

  task automatic test_branch;
    pulse_start();
    drive(4'd6, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, -32'sd4);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (imem_wdata !== 32'hFE208EE3) begin errors++; $display("FAIL branch_word got %h want fe208ee3", imem_wdata); end
    tick();
    tick();
  endtask

  task automatic test_formats;
    pulse_start();
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: drive(4'd3, 5'd4, 5'd3, 5'd0, 3'd5, 1'b1, 32'd3);
        1: drive(4'd7, 5'd1, 5'd31, 5'd31, 3'd7, 1'b1, 32'd8);
        2: drive(4'd8, 5'd0, 5'd1, 5'd9, 3'd7, 1'b1, 32'd0);
        3: drive(4'd9, 5'd2, 5'd5, 5'd5, 3'd3, 1'b0, 32'h0000_0001);
        default: drive(4'd12, 5'd9, 5'd9, 5'd9, 3'd7, 1'b1, 32'hFFFF_FFFF);
      endcase
      tick();
      checks++;
      if (imem_wdata !== fmt_exp[i] || imem_addr !== 32'(i * 4)) begin
        errors++;
        $display("FAIL fmt%0d got %h@%h want %h@%h", i, imem_wdata, imem_addr, fmt_exp[i], i * 4);
      end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (count !== 16'd5) begin errors++; $display("FAIL fmt_count got %0d want 5", count); end
    tick();
  endtask

  task automatic test_depth;
    int acc = 0, wr = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pulse_start();
    drive(4'd2, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd1);
    in_valid = 1'b1;
    imem_ready = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      acc += int'(in_valid && in_ready2);
      wr += int'(imem_we2 && imem_ready);
      tick();
    end
    checks++; if (acc !== 2 || wr !== 2) begin errors++; $display("FAIL depth_xfers got acc=%0d wr=%0d want 2/2", acc, wr); end
    checks++; if (in_ready2 !== 1'b0 || done2 !== 1'b1) begin errors++; $display("FAIL depth_stop got rdy=%b done=%b want 0/1", in_ready2, done2); end
    checks++; if (count2 !== 16'd2 || imem_addr2 !== 32'h108) begin errors++; $display("FAIL depth_state got count=%0d addr=%h want 2/108", count2, imem_addr2); end
    in_valid = 1'b0;
    pulse_start();
    in_valid = 1'b1;
    imem_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    checks++; if (imem_we2 !== 1'b1) begin errors++; $display("FAIL rst_pending got %b want 1", imem_we2); end
    rst = 1'b1;
    #1;
    checks++; if (imem_we2 !== 1'b0) begin errors++; $display("FAIL rst_async_we got %b want 0", imem_we2); end
    tick();
    checks++; if (count2 !== 16'd0 || imem_addr2 !== 32'h100 || done2 !== 1'b0) begin errors++; $display("FAIL rst_vals got count=%0d addr=%h done=%b want 0/100/0", count2, imem_addr2, done2); end
    rst = 1'b0;
    in_valid = 1'b1;
    imem_ready = 1'b1;
    tick();
    checks++; if (in_ready2 !== 1'b0 || imem_we2 !== 1'b0) begin errors++; $display("FAIL rst_idle got rdy=%b we=%b want 0/0", in_ready2, imem_we2); end
    in_valid = 1'b0;
    tick();
  endtask

`ifdef RV_ENC_RANGE_CHECK_EN
  task automatic test_range;
    pulse_start();
    drive(4'd2, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd4096);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (imem_wdata !== 32'h0 || imem_we !== 1'b1) begin errors++; $display("FAIL range_nop got %h we=%b want 0/1", imem_wdata, imem_we); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL range_err got %b want 1", err); end
    tick();
    tick();
    checks++; if (err !== 1'b1 || count !== 16'd1) begin errors++; $display("FAIL range_sticky got err=%b count=%0d want 1/1", err, count); end
    pulse_start();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL range_clear got %b want 0", err); end
  endtask
`endif

  initial begin
    test_reset();
    test_r_type();
    test_back_to_back();
    test_stall();
    test_branch();
    test_formats();
    test_depth();
`ifdef RV_ENC_RANGE_CHECK_EN
    test_range();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
